// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit ALU: operand read, issue, writeback.
// Three-cycle IDLE/ISSUE/DONE sequence with a small internal register file.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REGS       = 4,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      instr_valid_in,
  output logic                      instr_ready_out,
  input  logic [7:0]                instr_opcode_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_dst_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src1_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src2_in,
  input  logic [DATA_WIDTH-1:0]     instr_imm_in,
  output logic                      alu_enable_out,
  output logic [7:0]                alu_opcode_out,
  output logic [DATA_WIDTH-1:0]     alu_input1_out,
  output logic [DATA_WIDTH-1:0]     alu_input2_out,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [4:0]                alu_flags_in,
  output logic                      result_valid_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic [4:0]                flags_out,
  output logic                      error_out,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_in,
  output logic [DATA_WIDTH-1:0]     dbg_data_out
);

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_EQ   = 8'd3;
  localparam logic [7:0] OP_GT   = 8'd4;
  localparam logic [7:0] OP_ADDI = 8'd9;
  localparam logic [7:0] OP_SUBI = 8'd10;
  localparam logic [7:0] OP_MOV  = 8'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0]     r_regs [NUM_REGS];
  logic [7:0]                r_op;
  logic [REG_ADDR_WIDTH-1:0] r_dst;
  logic [REG_ADDR_WIDTH-1:0] r_src1;
  logic [REG_ADDR_WIDTH-1:0] r_src2;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [4:0]                r_flags;
  logic                      r_ok;

  logic w_arith;
  logic w_cmp;
  logic w_mov;
  logic w_ok;
  logic w_imm;

  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                   (r_op == OP_ADDI) || (r_op == OP_SUBI);
  assign w_cmp   = (r_op == OP_EQ) || (r_op == OP_GT);
  assign w_mov   = (r_op == OP_MOV);
  assign w_ok    = w_arith || w_cmp || w_mov;
  assign w_imm   = (r_op == OP_ADDI) || (r_op == OP_SUBI);

  assign result_out   = r_result;
  assign flags_out    = r_flags;
  assign dbg_data_out = r_regs[dbg_addr_in];

  // Next-state and ALU drive; ALU bus is zero outside ISSUE.
  always_comb begin
    w_next           = r_state;
    instr_ready_out  = 1'b0;
    alu_enable_out   = 1'b0;
    alu_opcode_out   = '0;
    alu_input1_out   = '0;
    alu_input2_out   = '0;
    result_valid_out = 1'b0;
    error_out        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        instr_ready_out = 1'b1;
        if (instr_valid_in) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_enable_out = 1'b1;
        alu_opcode_out = r_op;
        alu_input1_out = r_regs[r_src1];
        alu_input2_out = w_imm ? r_imm : r_regs[r_src2];
        w_next         = S_DONE;
      end
      S_DONE: begin
        result_valid_out = r_ok;
        error_out        = ~r_ok;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, instruction latch, writeback of result and flags.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dst    <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_imm    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_ok     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && instr_valid_in) begin
        r_op   <= instr_opcode_in;
        r_dst  <= instr_dst_in;
        r_src1 <= instr_src1_in;
        r_src2 <= instr_src2_in;
        r_imm  <= instr_imm_in;
      end
      if (r_state == S_ISSUE) begin
        r_ok <= w_ok;
        if (w_ok) begin
          r_regs[r_dst] <= alu_result_in;
          r_result      <= alu_result_in;
        end
        if (w_arith) r_flags <= alu_flags_in;
        if (w_cmp) r_flags[2:1] <= alu_flags_in[2:1];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU model.
// Vector table plus hand sequences for busy-hold and mid-issue reset.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [7:0] op;
  logic [1:0] dst, s1, s2;
  logic [7:0] imm;
  logic       en;
  logic [7:0] a_op, a_in1, a_in2;
  logic [7:0] a_res;
  logic [4:0] a_fl;
  logic       rv;
  logic [7:0] res;
  logic [4:0] fl;
  logic       err;
  logic [1:0] dbg_a;
  logic [7:0] dbg_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clock_in(clk), .reset_in(rst),
    .instr_valid_in(valid), .instr_ready_out(ready),
    .instr_opcode_in(op), .instr_dst_in(dst),
    .instr_src1_in(s1), .instr_src2_in(s2),
    .instr_imm_in(imm),
    .alu_enable_out(en), .alu_opcode_out(a_op),
    .alu_input1_out(a_in1), .alu_input2_out(a_in2),
    .alu_result_in(a_res), .alu_flags_in(a_fl),
    .result_valid_out(rv), .result_out(res),
    .flags_out(fl), .error_out(err),
    .dbg_addr_in(dbg_a), .dbg_data_out(dbg_d)
  );

  logic [8:0] m_s9;
  // ALU model: flags {overflow, carry(borrow on sub), zero, sign, parity}.
  always_comb begin
    m_s9  = '0;
    a_res = '0;
    a_fl  = '0;
    if (en) begin
      case (a_op)
        8'd0, 8'd9: begin
          m_s9    = {1'b0, a_in1} + {1'b0, a_in2};
          a_res   = m_s9[7:0];
          a_fl[3] = m_s9[8];
          a_fl[4] = (a_in1[7] == a_in2[7]) && (a_res[7] != a_in1[7]);
        end
        8'd1, 8'd10: begin
          a_res   = a_in1 - a_in2;
          a_fl[3] = a_in1 < a_in2;
          a_fl[4] = (a_in1[7] != a_in2[7]) && (a_res[7] != a_in1[7]);
        end
        8'd2:  a_res = a_in1 * a_in2;
        8'd3:  a_res = (a_in1 == a_in2) ? 8'd1 : 8'd0;
        8'd4:  a_res = ($signed(a_in1) > $signed(a_in2)) ? 8'd1 : 8'd0;
        8'd11: a_res = a_in1;
        default: a_res = '0;
      endcase
      a_fl[2] = (a_res == 8'd0);
      a_fl[1] = a_res[7];
      a_fl[0] = ^a_res;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [1:0] dst, s1, s2;
    logic [7:0] imm;
    logic       hold;
    logic       err;
    logic [7:0] res;
    logic [4:0] fl;
    logic [7:0] dval;
  } vec_t;

  vec_t v[9];

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  task automatic run(input vec_t t, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_ready();
    op = t.op; dst = t.dst; s1 = t.s1; s2 = t.s2; imm = t.imm;
    valid = 1'b1;
    @(posedge clk); #1;
    if (t.hold) begin
      op = 8'd0; dst = 2'd1; s1 = 2'd3; imm = 8'd7;
    end else valid = 1'b0;
    chk({p, "_issue_ready"}, {31'd0, ready}, 32'd0);
    chk({p, "_issue_en"}, {31'd0, en}, 32'd1);
    chk({p, "_issue_op"}, {24'd0, a_op}, {24'd0, t.op});
    @(posedge clk); #1;
    chk({p, "_done_ready"}, {31'd0, ready}, 32'd0);
    chk({p, "_done_en"}, {31'd0, en}, 32'd0);
    chk({p, "_rv"}, {31'd0, rv}, {31'd0, ~t.err});
    chk({p, "_err"}, {31'd0, err}, {31'd0, t.err});
    chk({p, "_res"}, {24'd0, res}, {24'd0, t.res});
    chk({p, "_flags"}, {27'd0, fl}, {27'd0, t.fl});
    @(posedge clk); #1;
    valid = 1'b0;
    chk({p, "_idle_ready"}, {31'd0, ready}, 32'd1);
    chk({p, "_idle_rv"}, {31'd0, rv | err}, 32'd0);
    dbg_a = t.dst; #1;
    chk({p, "_dst_reg"}, {24'd0, dbg_d}, {24'd0, t.dval});
  endtask

  initial begin
    v[0] = '{8'd9,  2'd0, 2'd0, 2'd0, 8'd100, 1'b0, 1'b0, 8'd100, 5'b00001, 8'd100};
    v[1] = '{8'd0,  2'd1, 2'd0, 2'd0, 8'd0,   1'b0, 1'b0, 8'hC8,  5'b10011, 8'hC8};
    v[2] = '{8'd3,  2'd2, 2'd0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd1,   5'b10001, 8'd1};
    v[3] = '{8'd1,  2'd2, 2'd3, 2'd0, 8'd0,   1'b0, 1'b0, 8'h9C,  5'b01010, 8'h9C};
    v[4] = '{8'd10, 2'd2, 2'd2, 2'd0, 8'd156, 1'b0, 1'b0, 8'd0,   5'b00100, 8'd0};
    v[5] = '{8'd4,  2'd3, 2'd0, 2'd1, 8'd0,   1'b0, 1'b0, 8'd1,   5'b00000, 8'd1};
    v[6] = '{8'd11, 2'd3, 2'd1, 2'd2, 8'd0,   1'b0, 1'b0, 8'hC8,  5'b00000, 8'hC8};
    v[7] = '{8'd2,  2'd0, 2'd0, 2'd1, 8'd0,   1'b1, 1'b1, 8'hC8,  5'b00000, 8'd100};
    v[8] = '{8'd0,  2'd1, 2'd3, 2'd0, 8'd0,   1'b0, 1'b0, 8'h2C,  5'b01001, 8'h2C};

    rst = 1'b1; valid = 1'b0; op = '0; dst = '0; s1 = '0; s2 = '0;
    imm = '0; dbg_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_pulses", {31'd0, rv | err}, 32'd0);
    chk("rst_res", {24'd0, res}, 32'd0);
    chk("rst_flags", {27'd0, fl}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_a = i[1:0]; #1;
      chk($sformatf("rst_r%0d", i), {24'd0, dbg_d}, 32'd0);
    end

    for (int i = 0; i < 9; i++) run(v[i], i);

    wait_ready();
    op = 8'd0; dst = 2'd0; s1 = 2'd0; s2 = 2'd0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mid_issue_en", {31'd0, en}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_pulses", {31'd0, rv | err}, 32'd0);
    chk("mid_alu_bus", {7'd0, en, a_op, a_in1, a_in2}, 32'd0);
    chk("mid_res", {24'd0, res}, 32'd0);
    chk("mid_flags", {27'd0, fl}, 32'd0);
    dbg_a = 2'd0; #1;
    chk("mid_r0", {24'd0, dbg_d}, 32'd0);
    @(posedge clk); #1;
    chk("mid_no_late_pulse", {31'd0, rv | err}, 32'd0);
    chk("mid_still_idle", {31'd0, ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
